// File: rtl/risk_tile_seq.sv
// risk_tile_seq: tile command sequencer for the risk unit (load/store/clear, 1..8 rows).
// Optional bounds checking is enabled by defining RISK_TILE_SEQ_BOUNDS_EN.
//
// state   | meaning
// S_IDLE  | ready for a command; done/err pulse here
// S_ISSUE | one row per cycle: address out, row pushed (load/store) or cleared
// S_DRAIN | last row pushed, waiting for the delay line to empty
module risk_tile_seq #(
    parameter int ADDR_W   = 15,
    parameter int STRIDE_W = 14,
    parameter int LD_LAT   = 4,
    parameter int ST_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4:0]          cmd_reg,
    input  logic [2:0]          cmd_rows,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [STRIDE_W-1:0] cmd_stride_x,
    input  logic [STRIDE_W-1:0] cmd_stride_y,
    output logic [2:0]          risk_func,
    output logic [4:0]          risk_reg,
    output logic [ADDR_W-1:0]   risk_addr,
    output logic [STRIDE_W-1:0] risk_stride_x,
    output logic [STRIDE_W-1:0] risk_stride_y,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int DEPTH = (LD_LAT > ST_LAT) ? LD_LAT : ST_LAT;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] FN_LOAD  = 3'b000;
    localparam logic [2:0] FN_STORE = 3'b001;
    localparam logic [2:0] FN_CLEAR = 3'b010;
    localparam logic [2:0] FN_NOP   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]          r_op;
    logic [4:0]          r_reg;
    logic [2:0]          r_rows;
    logic [2:0]          r_row;
    logic [STRIDE_W-1:0] r_stride_y;
    logic [STRIDE_W-1:0] r_stride_x;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_drain_cnt;
    logic                r_done;
    logic                r_err;

    logic [DEPTH-1:0]      r_dl_vld;
    logic [DEPTH-1:0][2:0] r_dl_func;
    logic [DEPTH-1:0][4:0] r_dl_reg;

    logic       w_accept;
    logic       w_reject;
    logic       w_is_mem;
    logic       w_last;
    logic       w_push;
    logic [4:0] w_row_reg;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_ld_hit;
    logic       w_st_hit;
    logic       w_clr_hit;

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_is_mem  = (r_op == OP_LOAD) || (r_op == OP_STORE);
    assign w_last    = (r_row == r_rows);
    assign w_row_reg = r_reg + 5'(r_row);
    assign w_push    = (r_state == S_ISSUE) && w_is_mem;

`ifdef RISK_TILE_SEQ_BOUNDS_EN
    localparam int SPAN_W = ADDR_W + STRIDE_W + 4;
    logic [5:0]        w_reg_end;
    logic [SPAN_W-1:0] w_addr_end;
    assign w_reg_end  = {1'b0, cmd_reg} + {3'b000, cmd_rows};
    assign w_addr_end = SPAN_W'(cmd_addr) + SPAN_W'(cmd_rows) * SPAN_W'(cmd_stride_y);
    assign w_reject   = w_reg_end[5]
                      || ((cmd_op != OP_CLEAR) && (w_addr_end >= (SPAN_W'(1) << ADDR_W)));
`else
    assign w_reject = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_reject || (cmd_op == OP_RSVD)) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = w_reject;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_last) begin
                    if (w_is_mem) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= OP_LOAD;
            r_reg       <= '0;
            r_rows      <= '0;
            r_row       <= '0;
            r_stride_y  <= '0;
            r_stride_x  <= '0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_dl_vld    <= '0;
            r_dl_func   <= '0;
            r_dl_reg    <= '0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;

            if (w_accept) begin
                r_op       <= cmd_op;
                r_reg      <= cmd_reg;
                r_rows     <= cmd_rows;
                r_row      <= '0;
                r_stride_y <= cmd_stride_y;
                r_stride_x <= cmd_stride_x;
                if (!w_reject && ((cmd_op == OP_LOAD) || (cmd_op == OP_STORE))) begin
                    r_addr <= cmd_addr;
                end
            end else if (r_state == S_ISSUE) begin
                if (!w_last) begin
                    r_row <= r_row + 3'd1;
                    if (w_is_mem) begin
                        r_addr <= r_addr + ADDR_W'(r_stride_y);
                    end
                end else if (w_is_mem) begin
                    r_drain_cnt <= (r_op == OP_LOAD) ? CNT_W'(LD_LAT - 1) : CNT_W'(ST_LAT - 1);
                end
            end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end

            // Loads and stores share one line; each is tapped at its own latency.
            r_dl_vld[0]  <= w_push;
            r_dl_func[0] <= (r_op == OP_LOAD) ? FN_LOAD : FN_STORE;
            r_dl_reg[0]  <= w_row_reg;
            for (int k = 1; k < DEPTH; k++) begin
                r_dl_vld[k]  <= r_dl_vld[k-1];
                r_dl_func[k] <= r_dl_func[k-1];
                r_dl_reg[k]  <= r_dl_reg[k-1];
            end
        end
    end

    assign w_ld_hit  = r_dl_vld[LD_LAT-1] && (r_dl_func[LD_LAT-1] == FN_LOAD);
    assign w_st_hit  = r_dl_vld[ST_LAT-1] && (r_dl_func[ST_LAT-1] == FN_STORE);
    assign w_clr_hit = (r_state == S_ISSUE) && (r_op == OP_CLEAR);

    always_comb begin
        risk_func = FN_NOP;
        risk_reg  = '0;
        if (w_ld_hit) begin
            risk_func = FN_LOAD;
            risk_reg  = r_dl_reg[LD_LAT-1];
        end else if (w_st_hit) begin
            risk_func = FN_STORE;
            risk_reg  = r_dl_reg[ST_LAT-1];
        end else if (w_clr_hit) begin
            risk_func = FN_CLEAR;
            risk_reg  = w_row_reg;
        end
    end

    assign risk_addr     = r_addr;
    assign risk_stride_x = r_stride_x;
    assign risk_stride_y = '0;
    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_risk_tile_seq.sv
// Directed bench for risk_tile_seq: load/store/clear/reserved, wrap, reset mid-command, back-to-back.
module tb_risk_tile_seq;

    localparam int ADDR_W   = 15;
    localparam int STRIDE_W = 14;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [4:0]          cmd_reg;
    logic [2:0]          cmd_rows;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [STRIDE_W-1:0] cmd_stride_x;
    logic [STRIDE_W-1:0] cmd_stride_y;
    logic [2:0]          risk_func;
    logic [4:0]          risk_reg;
    logic [ADDR_W-1:0]   risk_addr;
    logic [STRIDE_W-1:0] risk_stride_x;
    logic [STRIDE_W-1:0] risk_stride_y;
    logic                busy;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_fail   = 0;

    risk_tile_seq #(
        .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .LD_LAT(4), .ST_LAT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_rows(cmd_rows),
        .cmd_addr(cmd_addr), .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
        .risk_func(risk_func), .risk_reg(risk_reg), .risk_addr(risk_addr),
        .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [4:0] rg, input logic [2:0] rows,
                           input logic [ADDR_W-1:0] addr, input logic [STRIDE_W-1:0] sx,
                           input logic [STRIDE_W-1:0] sy);
        cmd_op       = op;
        cmd_reg      = rg;
        cmd_rows     = rows;
        cmd_addr     = addr;
        cmd_stride_x = sx;
        cmd_stride_y = sy;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        set_cmd(2'd0, 5'd0, 3'd0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;

        // reset / idle state
        chk("rst_func",  32'(risk_func), 32'h7);
        chk("rst_reg",   32'(risk_reg), 0);
        chk("rst_addr",  32'(risk_addr), 0);
        chk("rst_sx",    32'(risk_stride_x), 0);
        chk("rst_sy",    32'(risk_stride_y), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_err",   32'(err), 0);
        tick();

        // load reg 4, 4 rows, addr 0x100, stride_y 0x10
        set_cmd(2'd0, 5'd4, 3'd3, 15'h0100, 14'h0005, 14'h0010);
        cmd_valid = 1'b1;
        chk("ld_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk("ld_addr", 32'(risk_addr), (c <= 4) ? 32'h100 + 32'((c - 1) * 16) : 32'h130);
            chk("ld_func", 32'(risk_func), (c >= 5 && c <= 8) ? 32'h0 : 32'h7);
            chk("ld_reg",  32'(risk_reg),  (c >= 5 && c <= 8) ? 32'(4 + c - 5) : 32'h0);
            chk("ld_done", 32'(done), (c == 9) ? 32'h1 : 32'h0);
            chk("ld_busy", 32'(busy), (c <= 8) ? 32'h1 : 32'h0);
            chk("ld_sx",   32'(risk_stride_x), 32'h5);
            tick();
        end
        chk("ld_done_end", 32'(done), 0);

        // store reg 0, 1 row, then clear reg 2 accepted in the done cycle
        set_cmd(2'd1, 5'd0, 3'd0, 15'h7FF0, 14'h0000, 14'h0003);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("st_addr", 32'(risk_addr), 32'h7FF0);
        chk("st_func1", 32'(risk_func), 32'h7);
        chk("st_busy", 32'(busy), 1);
        tick();
        chk("st_func2", 32'(risk_func), 32'h1);
        chk("st_reg2",  32'(risk_reg), 0);
        chk("st_done2", 32'(done), 0);
        tick();
        chk("st_done3",  32'(done), 1);
        chk("st_ready3", 32'(cmd_ready), 1);
        chk("st_func3",  32'(risk_func), 32'h7);
        set_cmd(2'd2, 5'd2, 3'd0, 15'h0000, 14'h0000, 14'h0000);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("clr_func", 32'(risk_func), 32'h2);
        chk("clr_reg",  32'(risk_reg), 2);
        chk("clr_busy", 32'(busy), 1);
        chk("clr_addr", 32'(risk_addr), 32'h7FF0);
        tick();
        chk("clr_done", 32'(done), 1);
        chk("clr_func5", 32'(risk_func), 32'h7);
        tick();

        // reserved op: completes immediately, no rows
        set_cmd(2'd3, 5'd0, 3'd0, 15'h0000, 14'h0000, 14'h0000);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("rsv_done", 32'(done), 1);
        chk("rsv_busy", 32'(busy), 0);
        chk("rsv_func", 32'(risk_func), 32'h7);
        chk("rsv_err",  32'(err), 0);
        tick();
        chk("rsv_done2", 32'(done), 0);
        tick();

        // load reg 30, 4 rows, addr 0x7FFF stride 1: wraps, or rejected with bounds checking
        set_cmd(2'd0, 5'd30, 3'd3, 15'h7FFF, 14'h0000, 14'h0001);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
`ifdef RISK_TILE_SEQ_BOUNDS_EN
        for (int c = 1; c <= 9; c++) begin
            chk("rej_err",  32'(err),  (c == 1) ? 32'h1 : 32'h0);
            chk("rej_done", 32'(done), (c == 1) ? 32'h1 : 32'h0);
            chk("rej_busy", 32'(busy), 0);
            chk("rej_func", 32'(risk_func), 32'h7);
            tick();
        end
`else
        for (int c = 1; c <= 9; c++) begin
            chk("wr_addr", 32'(risk_addr), (c <= 4) ? 32'((32'h7FFF + c - 1) & 32'h7FFF) : 32'h2);
            chk("wr_func", 32'(risk_func), (c >= 5 && c <= 8) ? 32'h0 : 32'h7);
            chk("wr_reg",  32'(risk_reg),  (c >= 5 && c <= 8) ? 32'((30 + c - 5) & 31) : 32'h0);
            chk("wr_done", 32'(done), (c == 9) ? 32'h1 : 32'h0);
            chk("wr_err",  32'(err), 0);
            tick();
        end
`endif

        // reset in cycle 3 of a 4-row load
        set_cmd(2'd0, 5'd4, 3'd3, 15'h0100, 14'h0000, 14'h0010);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 4; c <= 12; c++) begin
            chk("mr_func",  32'(risk_func), 32'h7);
            chk("mr_done",  32'(done), 0);
            chk("mr_ready", 32'(cmd_ready), 1);
            chk("mr_busy",  32'(busy), 0);
            tick();
        end

        // cmd_valid held during a busy 2-row store; next load accepted in the done cycle
        set_cmd(2'd1, 5'd0, 3'd1, 15'h0200, 14'h0000, 14'h0020);
        cmd_valid = 1'b1;
        tick();
        set_cmd(2'd0, 5'd8, 3'd0, 15'h0400, 14'h0000, 14'h0040);
        chk("hv_ready1", 32'(cmd_ready), 0);
        chk("hv_addr1",  32'(risk_addr), 32'h200);
        tick();
        chk("hv_ready2", 32'(cmd_ready), 0);
        chk("hv_addr2",  32'(risk_addr), 32'h220);
        chk("hv_func2",  32'(risk_func), 32'h1);
        chk("hv_reg2",   32'(risk_reg), 0);
        tick();
        chk("hv_ready3", 32'(cmd_ready), 0);
        chk("hv_addr3",  32'(risk_addr), 32'h220);
        chk("hv_func3",  32'(risk_func), 32'h1);
        chk("hv_reg3",   32'(risk_reg), 1);
        tick();
        chk("hv_done4",  32'(done), 1);
        chk("hv_ready4", 32'(cmd_ready), 1);
        chk("hv_addr4",  32'(risk_addr), 32'h220);
        chk("hv_func4",  32'(risk_func), 32'h7);
        tick();
        cmd_valid = 1'b0;
        chk("hv_addr5", 32'(risk_addr), 32'h400);
        chk("hv_busy5", 32'(busy), 1);
        chk("hv_done5", 32'(done), 0);
        tick();
        for (int c = 6; c <= 8; c++) begin
            chk("hv_func_gap", 32'(risk_func), 32'h7);
            tick();
        end
        chk("hv_func9", 32'(risk_func), 32'h0);
        chk("hv_reg9",  32'(risk_reg), 8);
        tick();
        chk("hv_done10", 32'(done), 1);
        chk("hv_ready10", 32'(cmd_ready), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
